// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode constants, datapath widths and arbiter FSM encoding
//               shared by the ALU arbiter and its sub-module.
// Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_OPW = 5;
  localparam int XLEN    = 32;

  localparam logic [ALU_OPW-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALU_OPW-1:0] ALU_SLL  = 5'd2;
  localparam logic [ALU_OPW-1:0] ALU_SLT  = 5'd3;
  localparam logic [ALU_OPW-1:0] ALU_SLTU = 5'd4;
  localparam logic [ALU_OPW-1:0] ALU_XOR  = 5'd5;
  localparam logic [ALU_OPW-1:0] ALU_SRL  = 5'd6;
  localparam logic [ALU_OPW-1:0] ALU_SRA  = 5'd7;
  localparam logic [ALU_OPW-1:0] ALU_OR   = 5'd8;
  localparam logic [ALU_OPW-1:0] ALU_AND  = 5'd9;
  localparam logic [ALU_OPW-1:0] ALU_EQ   = 5'd10;
  localparam logic [ALU_OPW-1:0] ALU_NEQ  = 5'd11;
  localparam logic [ALU_OPW-1:0] ALU_LT   = 5'd12;
  localparam logic [ALU_OPW-1:0] ALU_GE   = 5'd13;
  localparam logic [ALU_OPW-1:0] ALU_LTU  = 5'd14;
  localparam logic [ALU_OPW-1:0] ALU_GEU  = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotating-priority arbiter; search starts at ptr
//               and wraps modulo NREQ. Returns one-hot grant and its index.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    if (enable) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = int'(ptr) + k;
        if (cand >= NREQ) begin
          cand = cand - NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (!found && (cand == i) && req[i]) begin
            grant[i] = 1'b1;
            idx      = IDW'(i);
            found    = 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU among NREQ requesters; one op in
//               flight, registered ALU inputs, tagged response channel.
//               Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [ALU_OPW*NREQ-1:0] req_op,
  input  logic [XLEN*NREQ-1:0]    req_lhs,
  input  logic [XLEN*NREQ-1:0]    req_rhs,
  output logic [NREQ-1:0]         req_ready,
  output logic [ALU_OPW-1:0]      alu_op,
  output logic [XLEN-1:0]         alu_lhs,
  output logic [XLEN-1:0]         alu_rhs,
  input  logic [XLEN-1:0]         alu_res,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [XLEN-1:0]         resp_data,
  output logic [IDW-1:0]          resp_id,
  output logic                    busy
);

  state_e              state_q, state_d;
  logic [ALU_OPW-1:0]  alu_op_q, alu_op_d;
  logic [XLEN-1:0]     alu_lhs_q, alu_lhs_d;
  logic [XLEN-1:0]     alu_rhs_q, alu_rhs_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]     resp_data_q, resp_data_d;
  logic [IDW-1:0]      resp_id_q, resp_id_d;

  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_idx;
  logic [IDW-1:0]      ptr;
  logic                arb_en;

  logic [ALU_OPW-1:0]  op_arr  [NREQ];
  logic [XLEN-1:0]     lhs_arr [NREQ];
  logic [XLEN-1:0]     rhs_arr [NREQ];
  logic [ALU_OPW-1:0]  sel_op;
  logic [XLEN-1:0]     sel_lhs;
  logic [XLEN-1:0]     sel_rhs;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i]  = req_op[i*ALU_OPW +: ALU_OPW];
    assign lhs_arr[i] = req_lhs[i*XLEN +: XLEN];
    assign rhs_arr[i] = req_rhs[i*XLEN +: XLEN];
  end

  // Grants are only offered in IDLE and never during the reset cycle.
  assign arb_en = (state_q == ST_IDLE) && !reset;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (ptr),
    .enable (arb_en),
    .grant  (grant),
    .idx    (grant_idx)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (|grant) begin
      if (grant_idx == IDW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + IDW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`endif

  always_comb begin
    sel_op  = '0;
    sel_lhs = '0;
    sel_rhs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = op_arr[i];
        sel_lhs = lhs_arr[i];
        sel_rhs = rhs_arr[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_lhs_d    = alu_lhs_q;
    alu_rhs_d    = alu_rhs_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          alu_op_d  = sel_op;
          alu_lhs_d = sel_lhs;
          alu_rhs_d = sel_rhs;
          id_d      = grant_idx;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_data_d  = alu_res;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      alu_op_q     <= '0;
      alu_lhs_q    <= '0;
      alu_rhs_q    <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_lhs_q    <= alu_lhs_d;
      alu_rhs_q    <= alu_rhs_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign req_ready  = grant;
  assign alu_op     = alu_op_q;
  assign alu_lhs    = alu_lhs_q;
  assign alu_rhs    = alu_rhs_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with a behavioural
//               ALU hooked to the registered ALU inputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [9:0]  req_op;
  logic [63:0] req_lhs;
  logic [63:0] req_rhs;
  logic [1:0]  req_ready;
  logic [4:0]  alu_op;
  logic [31:0] alu_lhs;
  logic [31:0] alu_rhs;
  logic [31:0] alu_res;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [2:0]  resp_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.NREQ(2), .IDW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .req_ready  (req_ready),
    .alu_op     (alu_op),
    .alu_lhs    (alu_lhs),
    .alu_rhs    (alu_rhs),
    .alu_res    (alu_res),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_EQ:   return {31'd0, a == b};
      ALU_NEQ:  return {31'd0, a != b};
      ALU_LT:   return {31'd0, $signed(a) < $signed(b)};
      ALU_GE:   return {31'd0, $signed(a) >= $signed(b)};
      ALU_LTU:  return {31'd0, a < b};
      ALU_GEU:  return {31'd0, a >= b};
      default:  return 32'd0;
    endcase
  endfunction

  always_comb alu_res = alu_model(alu_op, alu_lhs, alu_rhs);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic [4:0] op, input logic [31:0] lhs,
                         input logic [31:0] rhs);
    req_op[id*5 +: 5]   = op;
    req_lhs[id*32 +: 32] = lhs;
    req_rhs[id*32 +: 32] = rhs;
  endtask

  // Called at a negedge in IDLE with resp_ready high; returns at the negedge
  // of the IDLE cycle following the response handshake.
  task automatic run_single(input int id, input logic [4:0] op, input logic [31:0] lhs,
                            input logic [31:0] rhs, input logic [31:0] exp);
    logic [1:0] onehot;
    onehot = (id == 0) ? 2'b01 : 2'b10;
    set_req(id, op, lhs, rhs);
    req_valid = onehot;
    #1 check("single_ready", 32'(req_ready), 32'(onehot));
    @(negedge clk);
    req_valid = 2'b00;
    check("single_alu_op", 32'(alu_op), 32'(op));
    check("single_alu_lhs", alu_lhs, lhs);
    check("single_alu_rhs", alu_rhs, rhs);
    check("single_exec_noresp", 32'(resp_valid), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_resp_valid", 32'(resp_valid), 32'd1);
    check("single_resp_data", resp_data, exp);
    check("single_resp_id", 32'(resp_id), 32'(id));
    @(negedge clk);
    check("single_done_valid", 32'(resp_valid), 32'd0);
    check("single_done_busy", 32'(busy), 32'd0);
  endtask

  // Both requesters valid; called at a negedge in IDLE, returns at next IDLE negedge.
  task automatic both_round(input logic [1:0] exp_gnt, input logic [31:0] exp_data,
                            input logic [2:0] exp_id);
    req_valid = 2'b11;
    #1 check("both_grant", 32'(req_ready), 32'(exp_gnt));
    @(negedge clk);
    check("both_exec_ready", 32'(req_ready), 32'd0);
    check("both_exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("both_resp_valid", 32'(resp_valid), 32'd1);
    check("both_resp_data", resp_data, exp_data);
    check("both_resp_id", 32'(resp_id), 32'(exp_id));
    check("both_resp_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("both_idle_valid", 32'(resp_valid), 32'd0);
  endtask

  typedef struct {
    int          id;
    logic [4:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{0, ALU_ADD,  32'd5,          32'd7,          32'h0000000C};
    vecs[1]  = '{1, ALU_SUB,  32'd10,         32'd3,          32'h00000007};
    vecs[2]  = '{0, ALU_SLT,  32'hFFFFFFFF,   32'd1,          32'h00000001};
    vecs[3]  = '{1, ALU_SLTU, 32'hFFFFFFFF,   32'd1,          32'h00000000};
    vecs[4]  = '{0, ALU_SRA,  32'h80000000,   32'd4,          32'hF8000000};
    vecs[5]  = '{1, ALU_SRL,  32'h80000000,   32'd4,          32'h08000000};
    vecs[6]  = '{0, ALU_SLL,  32'd1,          32'd31,         32'h80000000};
    vecs[7]  = '{1, ALU_XOR,  32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0};
    vecs[8]  = '{0, ALU_EQ,   32'd3,          32'd3,          32'h00000001};
    vecs[9]  = '{1, ALU_GEU,  32'd1,          32'hFFFFFFFF,   32'h00000000};
    vecs[10] = '{0, ALU_LT,   32'h80000000,   32'd0,          32'h00000001};
    vecs[11] = '{1, 5'h1F,    32'd3,          32'd4,          32'h00000000};

    reset      = 1'b1;
    req_valid  = 2'b00;
    req_op     = '0;
    req_lhs    = '0;
    req_rhs    = '0;
    resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    req_valid = 2'b11;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_lhs", alu_lhs, 32'd0);
    check("rst_alu_rhs", alu_rhs, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_single(vecs[i].id, vecs[i].op, vecs[i].lhs, vecs[i].rhs, vecs[i].exp);
    end
    check("hold_alu_op", 32'(alu_op), 32'h1F);

    // Contention: pointer is 0 after the last table vector (id 1).
    set_req(0, ALU_SUB, 32'd10, 32'd3);
    set_req(1, ALU_SLT, 32'hFFFFFFFF, 32'd1);
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      both_round(2'b01, 32'd7, 3'd0);
`else
      if (k % 2 == 0) both_round(2'b01, 32'd7, 3'd0);
      else            both_round(2'b10, 32'd1, 3'd1);
`endif
    end
    req_valid = 2'b00;

    // Ordering: serve req0 alone so the pointer moves to 1, then both collide.
    run_single(0, ALU_SUB, 32'd10, 32'd3, 32'd7);
`ifdef ALU_ARB_FIXED_PRIO_EN
    both_round(2'b01, 32'd7, 3'd0);
    both_round(2'b01, 32'd7, 3'd0);
`else
    both_round(2'b10, 32'd1, 3'd1);
    both_round(2'b01, 32'd7, 3'd0);
`endif
    req_valid = 2'b00;

    // Backpressure in RESP with another requester waiting.
    resp_ready = 1'b0;
    set_req(0, ALU_ADD, 32'd100, 32'd23);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b10;
    check("bp_exec_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_data", resp_data, 32'd123);
      check("bp_resp_id", 32'(resp_id), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("bp_single_hs", 32'(resp_valid), 32'd0);

    // Reset while the operation is in EXEC.
    set_req(0, ALU_SRA, 32'h80000000, 32'd4);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    check("rexec_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rexec_alu_op", 32'(alu_op), 32'd0);
    check("rexec_alu_lhs", alu_lhs, 32'd0);
    check("rexec_alu_rhs", alu_rhs, 32'd0);
    check("rexec_resp_valid", 32'(resp_valid), 32'd0);
    check("rexec_resp_data", resp_data, 32'd0);
    check("rexec_resp_id", 32'(resp_id), 32'd0);
    check("rexec_busy0", 32'(busy), 32'd0);
    check("rexec_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rexec_no_resp", 32'(resp_valid), 32'd0);
    end
    set_req(0, ALU_SUB, 32'd10, 32'd3);
    set_req(1, ALU_SLT, 32'hFFFFFFFF, 32'd1);
    both_round(2'b01, 32'd7, 3'd0);
    req_valid = 2'b00;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
